// File: rtl/add_sub_arb_pkg.sv
// ============================================================================
// add_sub_arb_pkg : shared types and constants for the add/sub arbiter slice
// Rev 1.0
// ============================================================================
`default_nettype none

package add_sub_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    localparam logic CTRL_ADD = 1'b0;
    localparam logic CTRL_SUB = 1'b1;

    localparam int OP_COUNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/optimal_add_sub.sv
// ============================================================================
// optimal_add_sub : Kogge-Stone parallel-prefix adder/subtractor, {cout, sum}
// Rev 1.0
// ============================================================================
`default_nettype none

module optimal_add_sub
    import add_sub_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  ctrl,
    output logic [DATA_WIDTH:0]   result
);

    localparam int LEVELS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                                w_cin;
    logic [DATA_WIDTH-1:0]               w_b;
    logic [DATA_WIDTH-1:0]               w_p0;
    logic [LEVELS:0][DATA_WIDTH-1:0]     w_g;
    logic [LEVELS-1:0][DATA_WIDTH-1:0]   w_p;
    logic [DATA_WIDTH:0]                 w_carry;

    always_comb begin
        w_cin   = (ctrl == CTRL_SUB);
        w_b     = w_cin ? ~op2 : op2;
        w_p0    = op1 ^ w_b;
        w_g     = '0;
        w_p     = '0;
        w_carry = '0;

        // Carry-in folded into bit 0 generate so the prefix tree yields true carries.
        w_g[0]    = op1 & w_b;
        w_g[0][0] = w_g[0][0] | (w_p0[0] & w_cin);
        w_p[0]    = w_p0;

        for (int k = 1; k <= LEVELS; k++) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (i >= (1 << (k - 1))) begin
                    w_g[k][i] = w_g[k-1][i] | (w_p[k-1][i] & w_g[k-1][i - (1 << (k - 1))]);
                    if (k < LEVELS) begin
                        w_p[k][i] = w_p[k-1][i] & w_p[k-1][i - (1 << (k - 1))];
                    end
                end else begin
                    w_g[k][i] = w_g[k-1][i];
                    if (k < LEVELS) begin
                        w_p[k][i] = w_p[k-1][i];
                    end
                end
            end
        end

        w_carry[0] = w_cin;
        for (int i = 1; i <= DATA_WIDTH; i++) begin
            w_carry[i] = w_g[LEVELS][i-1];
        end

        result = {w_carry[DATA_WIDTH], w_p0 ^ w_carry[DATA_WIDTH-1:0]};
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin grant starting the search at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_sel;

    // Requests at or above ptr win first; otherwise wrap to the lowest index.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (ID_W'(i) >= ptr);
        end
        w_sel = (|(req & w_mask)) ? (req & w_mask) : req;
    end

    always_comb begin
        gnt_idx = '0;
        gnt_oh  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                gnt_idx = ID_W'(i);
            end
        end
        if (|req) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/add_sub_arbiter.sv
// ============================================================================
// add_sub_arbiter : round-robin sharing of one add/sub datapath, 1-deep output
// Rev 1.0
// ============================================================================
`default_nettype none

module add_sub_arbiter
    import add_sub_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    input  logic [NUM_REQ-1:0]            req_ctrl,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH:0]           rsp_result,
    output logic [ID_W-1:0]               rsp_id,
    output logic                          rsp_ctrl,
    output logic [OP_COUNT_W-1:0]         op_count
);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         w_gnt_idx;
    logic [NUM_REQ-1:0]      w_gnt_oh;
    logic                    w_can_accept;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_op1;
    logic [DATA_WIDTH-1:0]   w_op2;
    logic                    w_ctrl;
    logic [DATA_WIDTH:0]     w_dp_result;
    logic [DATA_WIDTH:0]     r_result;
    logic [ID_W-1:0]         r_id;
    logic                    r_ctrl;
    logic [OP_COUNT_W-1:0]   r_op_count;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt_oh  (w_gnt_oh),
        .gnt_idx (w_gnt_idx)
    );

    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;
    assign w_accept     = w_can_accept && (|req_valid);

    always_comb begin
        w_op1  = '0;
        w_op2  = '0;
        w_ctrl = CTRL_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_op1  = req_op1[i*DATA_WIDTH +: DATA_WIDTH];
                w_op2  = req_op2[i*DATA_WIDTH +: DATA_WIDTH];
                w_ctrl = req_ctrl[i];
            end
        end
    end

    optimal_add_sub #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .op1    (w_op1),
        .op2    (w_op2),
        .ctrl   (w_ctrl),
        .result (w_dp_result)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a fresh accept always refills, a drained slot empties
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output logic
    always_comb begin
        rsp_valid = (r_state == ST_FULL);
        req_ready = w_accept ? w_gnt_oh : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_result <= '0;
            r_id     <= '0;
            r_ctrl   <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
            r_result <= w_dp_result;
            r_id     <= w_gnt_idx;
            r_ctrl   <= w_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            r_op_count <= r_op_count + OP_COUNT_W'(1);
        end
    end

    assign rsp_result = r_result;
    assign rsp_id     = r_id;
    assign rsp_ctrl   = r_ctrl;
    assign op_count   = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_arbiter.sv
// ============================================================================
// tb_add_sub_arbiter : directed stimulus with a scoreboard-driven response monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_add_sub_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic                clk;
    logic                rst_n;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*DW-1:0]    req_op1;
    logic [NR*DW-1:0]    req_op2;
    logic [NR-1:0]       req_ctrl;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DW:0]         rsp_result;
    logic [1:0]          rsp_id;
    logic                rsp_ctrl;
    logic [15:0]         op_count;

    typedef struct packed {
        logic [DW:0] res;
        logic [1:0]  id;
        logic        ctrl;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    logic [15:0] exp_cnt;
    logic [8:0]  fair_exp [4];
    logic        fair_ctrl [4];

    add_sub_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_ctrl   (rsp_ctrl),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] r, input int id, input logic c);
        return {r, 2'(id), c};
    endfunction

    task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic c);
        req_op1[idx*DW +: DW] = a;
        req_op2[idx*DW +: DW] = b;
        req_ctrl[idx]         = c;
    endtask

    // Single request from one requester: accept, then one-cycle latency check.
    task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [8:0] res, input string name);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(idx, a, b, c);
        req_valid[idx] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[idx]) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: req_ready never asserted, got 0x%0h required 0x%0h", name, req_ready, 1 << idx);
            req_valid[idx] = 1'b0;
        end else begin
            chk({name, "_req_ready"}, 32'(req_ready), 32'(1) << idx);
            sb_q.push_back(mk(res, idx, c));
            @(posedge clk); #1;
            req_valid[idx] = 1'b0;
            @(negedge clk);
            chk({name, "_latency_valid"}, 32'(rsp_valid), 32'd1);
        end
    endtask

    task automatic drain_count(input string name, input logic [15:0] want);
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d responses outstanding, required 0", name, sb_q.size());
        end
        @(posedge clk);
        @(negedge clk);
        chk(name, 32'(op_count), 32'(want));
    endtask

    // Requester 0 streams N back-to-back 1+1 additions.
    task automatic burst(input int num, input string name);
        int got;
        got = 0;
        @(posedge clk); #1;
        set_req(0, 8'd1, 8'd1, 1'b0);
        req_valid[0] = 1'b1;
        for (int n = 0; n < num + 20 && got < num; n++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                sb_q.push_back(mk(9'h002, 0, 1'b0));
                got++;
            end
        end
        if (got != num) begin
            checks++;
            errors++;
            $display("FAIL %s: accepted %0d, required %0d", name, got, num);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
    endtask

    // Monitor: every response handshake pops and compares the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id %0d result 0x%0h, required no response", rsp_id, rsp_result);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_result", 32'(rsp_result), 32'(e.res));
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_ctrl", 32'(rsp_ctrl), 32'(e.ctrl));
                end
                chk("op_count_before_hs", 32'(op_count), 32'(exp_cnt));
                exp_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = '0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b0;
        fair_exp[0] = 9'h011; fair_ctrl[0] = 1'b0;   // 16 + 1
        fair_exp[1] = 9'h11E; fair_ctrl[1] = 1'b1;   // 50 - 20
        fair_exp[2] = 9'h1FE; fair_ctrl[2] = 1'b0;   // 255 + 255
        fair_exp[3] = 9'h0FF; fair_ctrl[3] = 1'b1;   // 0 - 1

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_ctrl", 32'(rsp_ctrl), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Single ADD and SUB with/without borrow
        issue(2, 8'd200, 8'd100, 1'b0, 9'h12C, "add_r2");
        drain_count("op_count_after_add", 16'd1);
        issue(0, 8'd10, 8'd3, 1'b1, 9'h107, "sub_noborrow");
        issue(0, 8'd5, 8'd7, 1'b1, 9'h0FE, "sub_borrow");
        issue(3, 8'd3, 8'd4, 1'b0, 9'h007, "add_r3");
        drain_count("op_count_after_sub", 16'd4);

        // Round-robin fairness, all requesters pending
        @(posedge clk); #1;
        set_req(0, 8'd16, 8'd1, 1'b0);
        set_req(1, 8'd50, 8'd20, 1'b1);
        set_req(2, 8'd255, 8'd255, 1'b0);
        set_req(3, 8'd0, 8'd1, 1'b1);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
            if (k > 0) chk("rr_throughput", 32'(rsp_valid), 32'd1);
            sb_q.push_back(mk(fair_exp[k % 4], k % 4, fair_ctrl[k % 4]));
            @(posedge clk); #1;
        end
        req_valid = '0;
        drain_count("op_count_after_rr", 16'd12);

        // Backpressure with requesters 1 and 3
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(1, 8'd100, 8'd1, 1'b0);
        set_req(3, 8'd7, 8'd8, 1'b0);
        req_valid = 4'b1010;
        @(negedge clk);
        chk("bp_first_grant", 32'(req_ready), 32'b0010);
        sb_q.push_back(mk(9'h065, 1, 1'b0));
        @(posedge clk); #1;
        set_req(1, 8'd40, 8'd50, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_result", 32'(rsp_result), 32'h065);
            chk("bp_hold_id", 32'(rsp_id), 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'b1000);
        sb_q.push_back(mk(9'h00F, 3, 1'b0));
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("bp_wrap_grant", 32'(req_ready), 32'b0010);
        sb_q.push_back(mk(9'h0F6, 1, 1'b1));
        @(posedge clk); #1;
        req_valid = '0;
        drain_count("op_count_after_bp", 16'd15);

        // Reset mid-operation: build op_count = 5 with a held result
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) issue(0, 8'd1, 8'd2, 1'b0, 9'h003, "pre_rst_add");
        drain_count("op_count_five", 16'd5);
        rsp_ready = 1'b0;
        issue(0, 8'd9, 8'd9, 1'b0, 9'h012, "held");
        chk("pre_rst_count", 32'(op_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_count", 32'(op_count), 32'd0);
        chk("async_rst_result", 32'(rsp_result), 32'd0);
        sb_q.delete();
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_grant", 32'(req_ready), 32'b0001);
        sb_q.push_back(mk(9'h012, 0, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        drain_count("op_count_post_rst", 16'd1);

        // Counter wrap
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        burst(65535, "wrap_burst");
        drain_count("op_count_ffff", 16'hFFFF);
        burst(1, "wrap_step0");
        drain_count("op_count_wrap0", 16'd0);
        burst(1, "wrap_step1");
        drain_count("op_count_wrap1", 16'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/add_sub_arbiter.md
# add_sub_arbiter

Round-robin arbiter and sequencer that shares one `optimal_add_sub` datapath between `NUM_REQ` requesters. Each requester presents an operand pair and an ADD/SUB control over a valid/ready handshake. The block grants one requester per cycle, computes the result, and registers it with the winning requester's index. The result is held on a single valid/ready response port until it is consumed.

## Interface
- `DATA_WIDTH`, 8, operand width; result is `DATA_WIDTH+1` bits.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`, grant index width (derived localparam).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req_valid` input `NUM_REQ`: per-requester request valid.
- `req_ready` output `NUM_REQ`: per-requester accept strobe; one-hot or zero.
- `req_op1` input `NUM_REQ*DATA_WIDTH`: flattened op1; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_op2` input `NUM_REQ*DATA_WIDTH`: flattened op2, same packing as `req_op1`.
- `req_ctrl` input `NUM_REQ`: per-requester 0 = ADD, 1 = SUB.
- `rsp_valid` output 1: registered result valid.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_result` output `DATA_WIDTH+1`: `{cout, sum}` as produced by the datapath.
- `rsp_id` output `ID_W`: index of the requester that owns `rsp_result`.
- `rsp_ctrl` output 1: ctrl of the owning request.
- `op_count` output 16: number of completed response handshakes; wraps at 2^16.

## Operation
- State machine, 2 states:
  - `EMPTY`: output register holds nothing.
  - `FULL`: output register holds a result.
- `can_accept = (state == EMPTY) || rsp_ready`.
- Arbitration, evaluated combinationally every cycle:
  - Search starts at `rr_ptr` and scans indices `rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …`.
  - The first index with `req_valid` set is `gnt`.
- `req_ready[gnt] = can_accept && |req_valid`. All other bits are 0.
- On accept (a `req_valid & req_ready` bit set):
  - Mux requester `gnt` operands into the datapath.
  - Register `{cout,sum}`, `gnt` and ctrl into the output register.
  - Go to (or stay in) `FULL`.
  - `rr_ptr <= (gnt == NUM_REQ-1) ? 0 : gnt+1`.
- `FULL` with `rsp_ready` and no new accept → `EMPTY`.
- `FULL` with `rsp_ready` and a new accept → stay in `FULL` with the new data (back-to-back, full throughput).
- `FULL` with no `rsp_ready`:
  - Output register is held stable.
  - All `req_ready` are 0.
  - `rr_ptr` is unchanged.
- `op_count` increments on every `rsp_valid && rsp_ready` and wraps from 16'hFFFF to 0.
- No request selected (`req_valid == 0`): `rr_ptr` is unchanged, nothing is registered.
- Arithmetic:
  - ADD gives `op1 + op2`.
  - SUB gives `op1 + ~op2 + 1`.
  - For SUB, `result[DATA_WIDTH]` = 1 means no borrow (op1 ≥ op2).
- Requesters must hold operands stable while `req_valid` is high and `req_ready` is low. The block does not check this.

## Timing
- Reset values:
  - `state = EMPTY`, `rr_ptr = 0`.
  - `rsp_valid = 0`, `rsp_result = 0`, `rsp_id = 0`, `rsp_ctrl = 0`.
  - `op_count = 0`.
  - `req_ready = 0`: combinational, and 0 whenever no request is pending.
- Latency: a request accepted in cycle N appears on `rsp_*` in cycle N+1.
- Throughput: one result per cycle while `rsp_ready` stays high.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `state` and `rsp_ready`. No other outputs depend combinationally on inputs.
- Reset assertion mid-transaction:
  - All registers clear immediately.
  - The in-flight result is dropped.
  - `op_count` clears.
- Reset release: `rsp_valid` stays 0 until the first post-reset accept.

## Structure
- Package `add_sub_arb_pkg` holds:
  - `typedef enum logic {ST_EMPTY, ST_FULL} arb_state_t`.
  - `localparam logic CTRL_ADD = 1'b0`, `CTRL_SUB = 1'b1`.
- Sub-module `rr_arbiter #(NUM_REQ)`:
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot `gnt_oh` and binary `gnt_idx`.
  - Purely combinational.
- The datapath is one `optimal_add_sub #(DATA_WIDTH)` instance fed from the operand mux.
- Pointer, state, output register and counter live in `add_sub_arbiter`.

## Test plan
Parameters for all scenarios: `DATA_WIDTH=8`, `NUM_REQ=4`.

1. Single ADD:
   - Stimulus: requester 2 sends op1 = 200, op2 = 100, ctrl = 0; `rsp_ready = 1`.
   - Response: `req_ready = 4'b0100` in cycle N; next cycle `rsp_valid = 1`, `rsp_result = 9'h12C`, `rsp_id = 2`, `op_count = 1` after the handshake.
2. SUB with and without borrow:
   - Requester 0 sends 10 − 3: `rsp_result = 9'h107`.
   - Requester 0 sends 5 − 7: `rsp_result = 9'h0FE`.
   - `rsp_ctrl = 1` for both.
3. Round-robin fairness:
   - Stimulus: all 4 requesters hold `req_valid` for 8 cycles with `rsp_ready = 1`.
   - Response: grant order 0,1,2,3,0,1,2,3 and one response per cycle.
4. Backpressure:
   - Stimulus: `rsp_ready = 0` for 3 cycles while requesters 1 and 3 are valid.
   - Response: the first result is held unchanged and `req_ready = 0` throughout. After `rsp_ready` rises, the next grant goes to the requester after the last one granted.
5. Reset mid-operation:
   - Stimulus: assert `rst_n = 0` asynchronously while `rsp_valid = 1` and `op_count = 5`.
   - Response: immediately `rsp_valid = 0`, `op_count = 0`, and after release the first grant goes to requester 0.
6. Counter wrap:
   - Stimulus: 65,537 back-to-back handshakes (or force the counter to 16'hFFFF).
   - Response: `op_count` reads 0 and then 1.
